// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage: single-cycle multiply, restoring divide
// (one quotient bit per cycle), and a one-cycle DoneMD pulse carrying the result and rd.
module ex_muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StartE,
  input  logic [2:0]            MulDivOpE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic [4:0]            RdE,
  input  logic                  FlushE,
  output logic                  StallMD,
  output logic                  BusyMD,
  output logic                  DoneMD,
  output logic [DATA_WIDTH-1:0] ResultMD,
  output logic [4:0]            RdMD
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [4:0]              rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                    sa_q, sa_d, sb_q, sb_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;

  // Multiplier: sign-extend to 2W so one unsigned multiply covers every signedness mix.
  logic                    mul_sa, mul_sb;
  logic [2*DATA_WIDTH-1:0] a_ext, b_ext, product;

  assign mul_sa  = (op_q != 3'b011);
  assign mul_sb  = (op_q == 3'b001);
  assign a_ext   = {{DATA_WIDTH{mul_sa & a_q[DATA_WIDTH-1]}}, a_q};
  assign b_ext   = {{DATA_WIDTH{mul_sb & b_q[DATA_WIDTH-1]}}, b_q};
  assign product = a_ext * b_ext;

  // Restoring divide step on magnitudes; quot_q shifts the dividend out MSB first.
  logic [DATA_WIDTH:0]     rem_shift, diff;
  logic                    q_bit;
  logic [DATA_WIDTH-1:0]   rem_next, quot_next, q_fin, r_fin;

  assign rem_shift = {rem_q, quot_q[DATA_WIDTH-1]};
  assign diff      = rem_shift - {1'b0, b_q};
  assign q_bit     = ~diff[DATA_WIDTH];
  assign rem_next  = q_bit ? diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
  assign quot_next = {quot_q[DATA_WIDTH-2:0], q_bit};
  assign q_fin     = (~op_q[0] & (sa_q ^ sb_q)) ? -quot_next : quot_next;
  assign r_fin     = (~op_q[0] & sa_q) ? -rem_next : rem_next;

  logic start_signed, start_ovf;
  assign start_signed = ~MulDivOpE[0];
  assign start_ovf    = start_signed && (SrcAE == MinNeg) && (&SrcBE);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (FlushE) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (StartE) begin
            op_d = MulDivOpE;
            rd_d = RdE;
            if (MulDivOpE[2]) begin
              sa_d = start_signed & SrcAE[DATA_WIDTH-1];
              sb_d = start_signed & SrcBE[DATA_WIDTH-1];
              a_d  = sa_d ? -SrcAE : SrcAE;
              b_d  = sb_d ? -SrcBE : SrcBE;
              if (SrcBE == '0) begin
                result_d = MulDivOpE[1] ? SrcAE : '1;
                state_d  = StDone;
              end else if (start_ovf) begin
                result_d = MulDivOpE[1] ? '0 : MinNeg;
                state_d  = StDone;
              end else begin
                cnt_d   = '0;
                quot_d  = a_d;
                rem_d   = '0;
                state_d = StDiv;
              end
            end else begin
              a_d     = SrcAE;
              b_d     = SrcBE;
              sa_d    = 1'b0;
              sb_d    = 1'b0;
              state_d = StMul;
            end
          end
        end
        StMul: begin
          result_d = (op_q == 3'b000) ? product[DATA_WIDTH-1:0]
                                      : product[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d  = StDone;
        end
        StDiv: begin
          quot_d = quot_next;
          rem_d  = rem_next;
          if (cnt_q == CntLast) begin
            result_d = op_q[1] ? r_fin : q_fin;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign StallMD  = ((state_q == StIdle) & StartE & ~FlushE) |
                    (state_q == StMul) | (state_q == StDiv);
  assign BusyMD   = (state_q == StMul) | (state_q == StDiv);
  assign DoneMD   = (state_q == StDone);
  assign ResultMD = result_q;
  assign RdMD     = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes expected results, a negedge monitor
// pops and compares on every DoneMD pulse.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        StartE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RdE;
  logic        FlushE;
  logic        StallMD, BusyMD, DoneMD;
  logic [31:0] ResultMD;
  logic [4:0]  RdMD;

  ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .StartE   (StartE),
    .MulDivOpE(MulDivOpE),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
    .RdE      (RdE),
    .FlushE   (FlushE),
    .StallMD  (StallMD),
    .BusyMD   (BusyMD),
    .DoneMD   (DoneMD),
    .ResultMD (ResultMD),
    .RdMD     (RdMD)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          at;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   issued = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && DoneMD === 1'b1) begin
      done_cnt++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got DoneMD with rd %0d, required none", RdMD);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, "_result"}, ResultMD, mon_e.res);
        check({mon_e.name, "_rd"}, {27'd0, RdMD}, {27'd0, mon_e.rd});
        check({mon_e.name, "_cycle"}, cyc, mon_e.at);
      end
    end
  end

  // Drives one instruction, holding StartE high like a stalled ID/EX until StallMD drops.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                        input int lat);
    exp_t e;
    int   stalls;
    logic s;
    bit   left;
    StartE    = 1'b1;
    MulDivOpE = op;
    SrcAE     = a;
    SrcBE     = b;
    RdE       = rd;
    e.res  = res;
    e.rd   = rd;
    e.at   = cyc + 1 + lat;
    e.name = name;
    q.push_back(e);
    issued++;
    stalls = 0;
    left   = 1'b0;
    for (int i = 0; i < 100 && !left; i++) begin
      @(negedge clk);
      s = StallMD;
      if (s) stalls++;
      @(posedge clk);
      #1;
      if (!s) left = 1'b1;
    end
    check({name, "_stalls"}, stalls, lat + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst = 1'b1; StartE = 1'b0; FlushE = 1'b0;
    MulDivOpE = '0; SrcAE = '0; SrcBE = '0; RdE = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", ResultMD, 32'h0);
    check("reset_rd", {27'd0, RdMD}, 32'h0);
    check("reset_done", {31'd0, DoneMD}, 32'h0);
    check("reset_busy", {31'd0, BusyMD}, 32'h0);
    check("reset_stall", {31'd0, StallMD}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Multiply: latency 1 (DONE two cycles after start edge numbering), 2 stalls.
    run_op("mul_7_m3",   3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 1);
    run_op("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 1);
    run_op("mulhsu_m1",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 1);
    run_op("mulh_min2",  3'b001, 32'h80000000, 32'h80000000, 5'd4, 32'h40000000, 1);
    // Iterative divide.
    run_op("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd5, 32'hFFFFFFFD, 32);
    run_op("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd6, 32'hFFFFFFFF, 32);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 32);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 32);
    run_op("div_20_m6",  3'b100, 32'd20, 32'hFFFFFFFA, 5'd9, 32'hFFFFFFFD, 32);
    run_op("rem_20_m6",  3'b110, 32'd20, 32'hFFFFFFFA, 5'd10, 32'd2, 32);
    // Special cases finish one edge after start.
    run_op("divu_by0",   3'b101, 32'd5, 32'd0, 5'd11, 32'hFFFFFFFF, 0);
    run_op("rem_by0",    3'b110, 32'd5, 32'd0, 5'd12, 32'd5, 0);
    run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 0);
    run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h0, 0);
    // Back-to-back divide then multiply with StartE never dropping.
    run_op("b2b_div",    3'b101, 32'd1000, 32'd10, 5'd15, 32'd100, 32);
    run_op("b2b_mul",    3'b000, 32'd1000, 32'd10, 5'd16, 32'd10000, 1);
    StartE = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_done_count", done_cnt, issued);
    check("b2b_queue_empty", q.size(), 0);

    // Flush during divide iteration 5.
    snap = done_cnt;
    StartE = 1'b1; MulDivOpE = 3'b101; SrcAE = 32'd100; SrcBE = 32'd7; RdE = 5'd20;
    @(posedge clk);
    #1;
    check("flush_busy_before", {31'd0, BusyMD}, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    FlushE = 1'b1;
    @(posedge clk);
    #1;
    check("flush_busy_after", {31'd0, BusyMD}, 32'h0);
    check("flush_idle_stall", {31'd0, StallMD}, 32'h0);
    @(posedge clk);
    #1;
    check("flush_blocks_start", {31'd0, BusyMD}, 32'h0);
    FlushE = 1'b0; StartE = 1'b0;
    check("flush_stall_low", {31'd0, StallMD}, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_done", done_cnt, snap);

    // Async reset at divide iteration 10.
    StartE = 1'b1; MulDivOpE = 3'b100; SrcAE = 32'hFFFFFFF9; SrcBE = 32'd2; RdE = 5'd21;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    check("rstdiv_busy", {31'd0, BusyMD}, 32'h1);
    StartE = 1'b0;
    rst = 1'b1;
    #1;
    check("rstdiv_result", ResultMD, 32'h0);
    check("rstdiv_rd", {27'd0, RdMD}, 32'h0);
    check("rstdiv_busy0", {31'd0, BusyMD}, 32'h0);
    check("rstdiv_done", {31'd0, DoneMD}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstdiv_stall", {31'd0, StallMD}, 32'h0);
    snap = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("rstdiv_no_done", done_cnt, snap);

    // Recovery after reset.
    run_op("divu_max_1", 3'b101, 32'hFFFFFFFF, 32'd1, 5'd22, 32'hFFFFFFFF, 32);
    StartE = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
